// File: rtl/stopwatch_ctrl.sv
// Stopwatch controller: start/stop and lap/clear sequencing, a 0.1 s prescaler,
// cascaded BCD tenths/seconds/minutes counters and a lap snapshot register.
module stopwatch_ctrl #(
  parameter int TICK_DIV = 5000000
) (
  input  logic       clk,
  input  logic       aclr,
  input  logic       btn_ss,
  input  logic       btn_lc,
  output logic [3:0] tenths,
  output logic [3:0] sec_lo,
  output logic [3:0] sec_hi,
  output logic [3:0] min,
  output logic       running,
  output logic       frozen
);

  // state   | meaning
  // S_IDLE  | cleared, waiting for start
  // S_RUN   | timebase advancing, live display
  // S_LAP   | timebase advancing, display holds the snapshot
  // S_PAUSE | timebase halted, prescaler phase retained
  typedef enum logic [1:0] {S_IDLE, S_RUN, S_LAP, S_PAUSE} state_t;

  localparam int PW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PRE_LAST = PW'(TICK_DIV - 1);

  state_t        state_q, state_d;
  logic          ss_prev_q, lc_prev_q;
  logic [PW-1:0] pre_q, pre_d;
  logic [3:0]    tenths_q, tenths_d;
  logic [3:0]    sec_lo_q, sec_lo_d;
  logic [3:0]    sec_hi_q, sec_hi_d;
  logic [3:0]    min_q, min_d;
  logic [15:0]   snap_q, snap_d;
  logic [15:0]   disp_q, disp_d;
  logic          running_q, frozen_q;

  logic ss_press, lc_press;
  logic adv, tick, clear_all;

  assign ss_press = btn_ss & ~ss_prev_q;
  // start/stop has priority when both buttons rise together
  assign lc_press = btn_lc & ~lc_prev_q & ~ss_press;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (ss_press) state_d = S_RUN;
      S_RUN: begin
        if (ss_press)      state_d = S_PAUSE;
        else if (lc_press) state_d = S_LAP;
      end
      S_LAP: begin
        if (ss_press)      state_d = S_PAUSE;
        else if (lc_press) state_d = S_RUN;
      end
      S_PAUSE: begin
        if (ss_press)      state_d = S_RUN;
        else if (lc_press) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // The prescaler only moves on edges that begin and end in a running state,
  // so stop/resume edges neither gain nor lose phase.
  always_comb begin
    adv       = ((state_q == S_RUN) || (state_q == S_LAP)) &&
                ((state_d == S_RUN) || (state_d == S_LAP));
    tick      = adv && (pre_q == PRE_LAST);
    clear_all = (state_q == S_PAUSE) && (state_d == S_IDLE);

    pre_d    = pre_q;
    tenths_d = tenths_q;
    sec_lo_d = sec_lo_q;
    sec_hi_d = sec_hi_q;
    min_d    = min_q;
    snap_d   = snap_q;

    if (clear_all) begin
      pre_d    = '0;
      tenths_d = '0;
      sec_lo_d = '0;
      sec_hi_d = '0;
      min_d    = '0;
    end else begin
      if (adv) pre_d = tick ? '0 : pre_q + PW'(1);
      if (tick) begin
        if (tenths_q == 4'd9) begin
          tenths_d = '0;
          if (sec_lo_q == 4'd9) begin
            sec_lo_d = '0;
            if (sec_hi_q == 4'd5) begin
              sec_hi_d = '0;
              min_d    = (min_q == 4'd9) ? 4'd0 : min_q + 4'd1;
            end else begin
              sec_hi_d = sec_hi_q + 4'd1;
            end
          end else begin
            sec_lo_d = sec_lo_q + 4'd1;
          end
        end else begin
          tenths_d = tenths_q + 4'd1;
        end
      end
    end

    if ((state_q == S_RUN) && (state_d == S_LAP))
      snap_d = {min_q, sec_hi_q, sec_lo_q, tenths_q};

    disp_d = (state_d == S_LAP) ? snap_d : {min_d, sec_hi_d, sec_lo_d, tenths_d};
  end

  always_ff @(posedge clk or negedge aclr) begin
    if (!aclr) begin
      state_q   <= S_IDLE;
      ss_prev_q <= 1'b1;
      lc_prev_q <= 1'b1;
      pre_q     <= '0;
      tenths_q  <= '0;
      sec_lo_q  <= '0;
      sec_hi_q  <= '0;
      min_q     <= '0;
      snap_q    <= '0;
      disp_q    <= '0;
      running_q <= 1'b0;
      frozen_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      ss_prev_q <= btn_ss;
      lc_prev_q <= btn_lc;
      pre_q     <= pre_d;
      tenths_q  <= tenths_d;
      sec_lo_q  <= sec_lo_d;
      sec_hi_q  <= sec_hi_d;
      min_q     <= min_d;
      snap_q    <= snap_d;
      disp_q    <= disp_d;
      running_q <= (state_d == S_RUN) || (state_d == S_LAP);
      frozen_q  <= (state_d == S_LAP);
    end
  end

  assign min     = disp_q[15:12];
  assign sec_hi  = disp_q[11:8];
  assign sec_lo  = disp_q[7:4];
  assign tenths  = disp_q[3:0];
  assign running = running_q;
  assign frozen  = frozen_q;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Scoreboard bench for stopwatch_ctrl: directed scenarios plus random button
// activity, checked against an elapsed-time model using plain integer arithmetic.
module tb_stopwatch_ctrl;

  localparam int TD = 4;

  logic       clk = 1'b0;
  logic       aclr;
  logic       btn_ss, btn_lc;
  logic [3:0] tenths, sec_lo, sec_hi, min;
  logic       running, frozen;

  stopwatch_ctrl #(.TICK_DIV(TD)) dut (
    .clk(clk), .aclr(aclr), .btn_ss(btn_ss), .btn_lc(btn_lc),
    .tenths(tenths), .sec_lo(sec_lo), .sec_hi(sec_hi), .min(min),
    .running(running), .frozen(frozen)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  logic [17:0] exp_q[$];

  // model: mode 0 idle, 1 run, 2 lap, 3 pause; time in tenths of a second
  int m_mode, m_time, m_phase, m_snap;
  bit m_prev_ss, m_prev_lc;

  function automatic void model_reset();
    m_mode = 0; m_time = 0; m_phase = 0; m_snap = 0;
    m_prev_ss = 1'b1; m_prev_lc = 1'b1;
  endfunction

  function automatic void model_step(bit ss, bit lc);
    bit pss, plc;
    int nxt;
    pss = ss && !m_prev_ss;
    plc = lc && !m_prev_lc && !pss;
    m_prev_ss = ss;
    m_prev_lc = lc;
    nxt = m_mode;
    case (m_mode)
      0: if (pss) nxt = 1;
      1: if (pss) nxt = 3; else if (plc) begin nxt = 2; m_snap = m_time; end
      2: if (pss) nxt = 3; else if (plc) nxt = 1;
      3: if (pss) nxt = 1; else if (plc) begin nxt = 0; m_time = 0; m_phase = 0; end
      default: nxt = 0;
    endcase
    if ((m_mode == 1 || m_mode == 2) && (nxt == 1 || nxt == 2)) begin
      m_phase++;
      if (m_phase == TD) begin
        m_phase = 0;
        m_time = (m_time + 1) % 6000;
      end
    end
    m_mode = nxt;
  endfunction

  function automatic logic [17:0] model_out();
    int shown;
    logic [3:0] dm, dsh, dsl, dt;
    shown = (m_mode == 2) ? m_snap : m_time;
    dm  = 4'(shown / 600);
    dsh = 4'((shown / 100) % 6);
    dsl = 4'((shown / 10) % 10);
    dt  = 4'(shown % 10);
    return {(m_mode == 1 || m_mode == 2), (m_mode == 2), dm, dsh, dsl, dt};
  endfunction

  function automatic logic [17:0] dut_out();
    return {running, frozen, min, sec_hi, sec_lo, tenths};
  endfunction

  // monitor: outputs are presented every cycle, compare 1 time unit after the edge
  initial begin
    logic [17:0] e, g;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        g = dut_out();
        checks++;
        if (g !== e) begin
          errors++;
          $display("FAIL cycle_out t=%0t got run=%b frz=%b %0d:%0d%0d.%0d expected run=%b frz=%b %0d:%0d%0d.%0d",
                   $time, g[17], g[16], g[15:12], g[11:8], g[7:4], g[3:0],
                   e[17], e[16], e[15:12], e[11:8], e[7:4], e[3:0]);
        end
      end
    end
  end

  // called at posedge+2: drive inputs for the next edge and queue the expectation
  task automatic step(input bit ss, input bit lc);
    btn_ss = ss;
    btn_lc = lc;
    model_step(ss, lc);
    exp_q.push_back(model_out());
    @(posedge clk);
    #2;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0);
  endtask

  task automatic press_ss();
    step(1'b1, 1'b0);
    step(1'b0, 1'b0);
  endtask

  task automatic press_lc();
    step(1'b0, 1'b1);
    step(1'b0, 1'b0);
  endtask

  task automatic check_zero(input string name);
    checks++;
    if (dut_out() !== 18'd0) begin
      errors++;
      $display("FAIL %s got %h expected 00000", name, dut_out());
    end
  endtask

  // async reset from posedge+2 with btn_ss held high through release
  task automatic do_reset(input string name);
    btn_ss = 1'b1;
    btn_lc = 1'b0;
    aclr = 1'b0;
    #1;
    check_zero(name);
    model_reset();
    @(posedge clk);
    #2;
    check_zero({name, "_held"});
    aclr = 1'b1;
  endtask

  task automatic run_until_time(input int t);
    int guard;
    guard = 0;
    while (m_time != t && guard < 100000) begin
      step(1'b0, 1'b0);
      guard++;
    end
    if (guard >= 100000) begin
      errors++;
      $display("FAIL wait_time got %0d expected %0d", m_time, t);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    aclr = 1'b0;
    btn_ss = 1'b1;
    btn_lc = 1'b0;
    model_reset();
    @(posedge clk);
    #2;
    check_zero("reset_initial");
    aclr = 1'b1;

    // held start button after release must not start the watch
    step(1'b1, 1'b0);
    step(1'b1, 1'b0);
    idle(3);

    // start, cascade through seconds and into minutes, then 9:59.9 wrap
    press_ss();
    idle(TD * 6000 + 3 * TD + 1);

    // lap freeze and release
    do_reset("reset_lap");
    step(1'b0, 1'b0);
    press_ss();
    run_until_time(13);
    press_lc();
    run_until_time(20);
    press_lc();
    idle(6);

    // pause at prescaler phase 2, resume, then clear from pause
    while (m_phase != 2) step(1'b0, 1'b0);
    press_ss();
    idle(100);
    press_ss();
    idle(2 * TD + 1);
    press_ss();
    press_lc();
    idle(3);

    // simultaneous presses in run, then async reset mid-run
    press_ss();
    idle(10);
    step(1'b1, 1'b1);
    step(1'b0, 1'b0);
    idle(3);
    press_ss();
    idle(7);
    do_reset("reset_midrun");
    step(1'b0, 1'b0);

    // random button levels
    for (int i = 0; i < 3000; i++)
      step($urandom_range(0, 7) == 0, $urandom_range(0, 5) == 0);

    idle(2);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
